// File: rtl/mips_pkg.sv
// Shared MINI-MIPS definitions: branch codes, opcodes, fetch FSM states.
package mips_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_EQ   = 4'd1;
    localparam logic [3:0] BR_NE   = 4'd2;
    localparam logic [3:0] BR_BGT  = 4'd3;
    localparam logic [3:0] BR_BGTE = 4'd4;
    localparam logic [3:0] BR_BLE  = 4'd5;
    localparam logic [3:0] BR_BLEQ = 4'd6;
    localparam logic [3:0] BR_BLEU = 4'd7;
    localparam logic [3:0] BR_BGTU = 4'd8;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALTED
    } fetch_state_e;

endpackage

// File: rtl/mips_branch_resolve.sv
// Combinational branch-condition evaluation and next-PC selection.
module mips_branch_resolve
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       instr_idx,
    input  logic [3:0]        branch,
    input  logic              jump,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              alu_zero,
    input  logic              alu_lt_s,
    input  logic              alu_lt_u,
    output logic [ADDR_W-1:0] next_pc
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic              taken;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] jmp_tgt;

    always_comb begin
        taken = 1'b0;
        case (branch)
            BR_EQ:   taken = alu_zero;
            BR_NE:   taken = !alu_zero;
            BR_BGT:  taken = !alu_lt_s && !alu_zero;
            BR_BGTE: taken = !alu_lt_s;
            BR_BLE:  taken = alu_lt_s;
            BR_BLEQ: taken = alu_lt_s || alu_zero;
            BR_BLEU: taken = alu_lt_u || alu_zero;
            BR_BGTU: taken = !alu_lt_u && !alu_zero;
            default: taken = 1'b0;
        endcase
    end

    assign br_off  = {{(ADDR_W-18){instr_idx[15]}}, instr_idx[15:0], 2'b00};
    assign jmp_tgt = {pc_plus4[ADDR_W-1:28], instr_idx, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = jr_target & WORD_MASK;
        end else if (jump) begin
            next_pc = jmp_tgt;
        end else if (taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Fetch/execute/halt sequencer: one instruction in flight, PC update on exec_done.
module mips_fetch_sequencer
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [3:0]        branch,
    input  logic              jump,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              alu_zero,
    input  logic              alu_lt_s,
    input  logic              alu_lt_u,
    input  logic              exec_done,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4 = pc_q + PC_INC;

    mips_branch_resolve #(
        .ADDR_W(ADDR_W)
    ) u_resolve (
        .pc_plus4  (pc_plus4),
        .instr_idx (instr_q[25:0]),
        .branch    (branch),
        .jump      (jump),
        .jr        (jr),
        .jr_target (jr_target),
        .alu_zero  (alu_zero),
        .alu_lt_s  (alu_lt_s),
        .alu_lt_u  (alu_lt_u),
        .next_pc   (next_pc)
    );

    // Only a response to a request we are actually driving is accepted.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_FETCH: begin
                if (imem_req_q && imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    pc_d    = next_pc;
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
        imem_req_d    = (state_d == ST_FETCH);
        instr_valid_d = (state_d == ST_EXEC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;

endmodule
